gf_inv_ctrl: RTL and testbench

GF_INV_CTRL -- requirements
Module: gf_inv_ctrl

---
 rtl/gf_pkg.sv | 20 ++
 rtl/gf_inv_ctrl_if.sv | 25 ++
 rtl/gf_inv_ctrl.sv | 148 ++++++++++++++
 tb/tb_gf_inv_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared GF(2^16) definitions: field width, reduction polynomial taps,
// iteration count for the square/multiply inversion and the FSM states.
package gf_pkg;

    localparam int M    = 16;
    localparam int ITER = M - 1;

    // x^16 + x^5 + x^3 + x^2 + 1, x^16 implied
    localparam logic [M-1:0] POLY_TAPS = 16'h002D;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SQ    = 3'd1,
        SQ_WB = 3'd2,
        MU    = 3'd3,
        MU_WB = 3'd4,
        DONE  = 3'd5
    } gf_state_e;

endpackage

// File: rtl/gf_inv_ctrl_if.sv
// Request/result and shared-multiplier signals of the GF inversion controller.
// master: the parent (issues start, owns the multiplier); slave: the controller.
interface gf_inv_ctrl_if #(parameter int M = gf_pkg::M);

    logic         start;
    logic [M-1:0] a_in;
    logic         busy;
    logic         done;
    logic         err;
    logic [M-1:0] c_out;
    logic [M-1:0] mul_a;
    logic [M-1:0] mul_b;
    logic [M-1:0] mul_c;

    modport master (
        output start, a_in, mul_c,
        input  busy, done, err, c_out, mul_a, mul_b
    );

    modport slave (
        input  start, a_in, mul_c,
        output busy, done, err, c_out, mul_a, mul_b
    );

endinterface

// File: rtl/gf_inv_ctrl.sv
// GF(2^M) inversion controller: c = a^(2^M-2) computed as the product of
// a^(2^i), i=1..ITER, by alternating square and multiply passes through a
// shared single-cycle registered multiplier owned by the parent.
// Optional: define GF_INV_ZERO_CHK_EN to short-circuit a zero operand
// straight to DONE with err=1; otherwise err is tied low and zero runs the
// full sequence (yielding 0).
module gf_inv_ctrl
    import gf_pkg::*;
#(
    parameter int M    = gf_pkg::M,
    parameter int ITER = gf_pkg::ITER
) (
    input  logic         clk,
    input  logic         rst,
    gf_inv_ctrl_if.slave bus
);

    localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;

    gf_state_e    state_q, state_d;
    logic [M-1:0] s_q, s_d;
    logic [M-1:0] r_q, r_d;
    logic [IW-1:0] iter_q, iter_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [M-1:0] c_q, c_d;
    logic [M-1:0] mul_a_q, mul_a_d;
    logic [M-1:0] mul_b_q, mul_b_d;
`ifdef GF_INV_ZERO_CHK_EN
    logic         err_q, err_d;
`endif

    // Next-state logic; multiplier operands are registered, so they are set
    // on the edge entering SQ/MU and read back as zero everywhere else.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        r_d     = r_q;
        iter_d  = iter_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        c_d     = c_q;
        mul_a_d = '0;
        mul_b_d = '0;
`ifdef GF_INV_ZERO_CHK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
`ifdef GF_INV_ZERO_CHK_EN
                    err_d  = 1'b0;
                    if (bus.a_in == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        c_d     = '0;
                        err_d   = 1'b1;
                    end else begin
`endif
                        state_d = SQ;
                        s_d     = bus.a_in;
                        r_d     = M'(1);
                        iter_d  = '0;
                        mul_a_d = bus.a_in;
                        mul_b_d = bus.a_in;
`ifdef GF_INV_ZERO_CHK_EN
                    end
`endif
                end
            end
            SQ: state_d = SQ_WB;
            SQ_WB: begin
                // s <- s*s, and present r * (new s) for the multiply pass
                state_d = MU;
                s_d     = bus.mul_c;
                mul_a_d = r_q;
                mul_b_d = bus.mul_c;
            end
            MU: state_d = MU_WB;
            MU_WB: begin
                r_d = bus.mul_c;
                if (iter_q == IW'(ITER - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    c_d     = bus.mul_c;
                end else begin
                    state_d = SQ;
                    iter_d  = iter_q + IW'(1);
                    mul_a_d = s_q;
                    mul_b_d = s_q;
                end
            end
            DONE: begin
                // start seen here is dropped; it is taken in the next IDLE
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            r_q     <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_q     <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
`ifdef GF_INV_ZERO_CHK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            r_q     <= r_d;
            iter_q  <= iter_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            c_q     <= c_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
`ifdef GF_INV_ZERO_CHK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.c_out = c_q;
    assign bus.mul_a = mul_a_q;
    assign bus.mul_b = mul_b_q;
`ifdef GF_INV_ZERO_CHK_EN
    assign bus.err   = err_q;
`else
    assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_gf_inv_ctrl.sv
// Bench for gf_inv_ctrl: supplies the registered GF multiplier, keeps a
// transaction-level model (accept / countdown / result) and compares the
// DUT outputs against it every cycle, plus directed literal checks.
module tb_gf_inv_ctrl;

    localparam int M    = 16;
    localparam int ITER = 15;
    localparam int LAT  = 4 * ITER + 1;
`ifdef GF_INV_ZERO_CHK_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = LAT;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gf_inv_ctrl_if #(.M(M)) bus();

    gf_inv_ctrl #(.M(M), .ITER(ITER)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vecs = 0;
    int errs = 0;

    function automatic logic [15:0] gf_mul(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        p = 32'h0;
        for (int i = 0; i < 16; i++)
            if (b[i]) p = p ^ ({16'h0, a} << i);
        for (int i = 31; i >= 16; i--)
            if (p[i]) p = p ^ (32'h1002D << (i - 16));
        return p[15:0];
    endfunction

    // a^(2^16-2) by plain binary exponentiation
    function automatic logic [15:0] gf_inv(input logic [15:0] a);
        logic [15:0] res, base;
        int e;
        res = 16'h1; base = a; e = 65534;
        while (e != 0) begin
            if (e & 1) res = gf_mul(res, base);
            base = gf_mul(base, base);
            e = e >> 1;
        end
        return res;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // shared multiplier: product one cycle after operands
    initial bus.mul_c = '0;
    always @(posedge clk) bus.mul_c <= gf_mul(bus.mul_a, bus.mul_b);

    // transaction model
    logic        m_busy, m_done, m_err;
    logic [15:0] m_c, m_exp;
    logic        m_experr;
    int          m_rem;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_err = 0; m_c = 0; m_rem = 0;
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_busy) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_done = 1; m_c = m_exp; m_err = m_experr;
            end
        end else if (bus.start) begin
            m_busy   = 1;
            m_exp    = (bus.a_in == 0) ? 16'h0 : gf_inv(bus.a_in);
            m_experr = (bus.a_in == 0) && (ZLAT == 1);
            m_rem    = ((bus.a_in == 0) ? ZLAT : LAT) - 1;
            if (m_rem == 0) begin
                m_done = 1; m_c = m_exp; m_err = m_experr;
            end
        end
    end

    // per-cycle compare, away from the active edge
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_err", bus.err, 0);
            chk("rst_c", bus.c_out, 0);
            chk("rst_mula", bus.mul_a, 0);
            chk("rst_mulb", bus.mul_b, 0);
        end else begin
            chk("busy", bus.busy, m_busy);
            chk("done", bus.done, m_done);
            if (m_done) begin
                chk("c_done", bus.c_out, m_c);
                chk("err_done", bus.err, m_err);
            end
            if (!m_busy) chk("c_held", bus.c_out, m_c);
            if (!m_busy || m_done) begin
                chk("mula_idle", bus.mul_a, 0);
                chk("mulb_idle", bus.mul_b, 0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || m_done) && n < 200) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask

    // one operation; lat = edges from accepting edge (edge 1) to done high
    task automatic run_op(input logic [15:0] a, input int inj_at, input logic [15:0] inj_a,
                          input bit hold, output logic [15:0] c, output logic e, output int lat);
        wait_idle();
        bus.a_in = a; bus.start = 1'b1;
        lat = 0; c = 16'hxxxx; e = 1'bx;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            bus.start = hold || (n == inj_at);
            if (inj_at > 0 && n >= inj_at) bus.a_in = inj_a;
            if (bus.done) begin
                lat = n; c = bus.c_out; e = bus.err;
                break;
            end
        end
    endtask

    logic [15:0] c, a;
    logic        e;
    int          lat, dn;

    initial begin
        bus.start = 1'b0;
        bus.a_in  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // model pins
        chk("pin_mul", gf_mul(16'h0002, 16'h8016), 16'h0001);
        chk("pin_inv2", gf_inv(16'h0002), 16'h8016);
        chk("pin_inv1", gf_inv(16'h0001), 16'h0001);

        run_op(16'h0001, 0, 0, 0, c, e, lat);
        chk("a1_c", c, 16'h0001); chk("a1_err", e, 0); chk("a1_lat", lat, 61);

        run_op(16'h0002, 0, 0, 0, c, e, lat);
        chk("a2_c", c, 16'h8016); chk("a2_lat", lat, 61);
        chk("a2_prod", gf_mul(c, 16'h0002), 1);

        run_op(16'h0000, 0, 0, 0, c, e, lat);
        chk("a0_c", c, 16'h0000);
`ifdef GF_INV_ZERO_CHK_EN
        chk("a0_err", e, 1); chk("a0_lat", lat, 1);
`else
        chk("a0_err", e, 0); chk("a0_lat", lat, 61);
`endif

        // new start at cycle 20 must be ignored
        run_op(16'h0003, 20, 16'h0005, 0, c, e, lat);
        bus.start = 1'b0;
        chk("inj_c", c, gf_inv(16'h0003)); chk("inj_lat", lat, 61);
        chk("inj_prod", gf_mul(c, 16'h0003), 1);

        // start held through the operation and the DONE cycle
        run_op(16'h0004, 0, 0, 1, c, e, lat);
        chk("hold_c", c, gf_inv(16'h0004)); chk("hold_lat", lat, 61);
        bus.a_in = 16'h0009;
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk); #1;
            if (n == 2) bus.start = 1'b0;
            if (bus.done) begin lat = n; c = bus.c_out; break; end
        end
        chk("b2b_lat", lat, 62); chk("b2b_c", c, gf_inv(16'h0009));

        // reset at cycle 30 aborts with no done pulse
        wait_idle();
        bus.a_in = 16'h0007; bus.start = 1'b1; dn = 0;
        for (int n = 1; n <= 80; n++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (n == 30) rst = 1'b1;
            if (n == 32) rst = 1'b0;
            if (bus.done) dn++;
        end
        chk("rst_no_done", dn, 0);
        run_op(16'h0002, 0, 0, 0, c, e, lat);
        chk("post_rst_c", c, 16'h8016); chk("post_rst_lat", lat, 61);

        // random nonzero operands
        for (int k = 0; k < 1000; k++) begin
            a = 16'($urandom_range(1, 65535));
            run_op(a, 0, 0, 0, c, e, lat);
            chk("rnd_lat", lat, 61);
            chk("rnd_prod", gf_mul(c, a), 1);
        end

        wait_idle();
        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
